// File: rtl/wb_regfile_scoreboard_if.sv
// Write-back, decode-read and issue signals shared by the MIPS register file
// and the pipeline stages around it.
interface wb_regfile_scoreboard_if;
    logic        RFWEW;
    logic        MtoRFSelW;
    logic [31:0] DMOutW;
    logic [31:0] ALUOutW;
    logic [4:0]  RFAW;
    logic [31:0] ResultW;
    logic [4:0]  RFRA1;
    logic [4:0]  RFRA2;
    logic [31:0] RFRD1;
    logic [31:0] RFRD2;
    logic        IssueEn;
    logic [4:0]  IssueA;
    logic        Busy1;
    logic        Busy2;
    logic        SbOvf;
    logic        SbUnf;

    modport master (
        output RFWEW, MtoRFSelW, DMOutW, ALUOutW, RFAW, RFRA1, RFRA2, IssueEn, IssueA,
        input  ResultW, RFRD1, RFRD2, Busy1, Busy2, SbOvf, SbUnf
    );

    modport slave (
        input  RFWEW, MtoRFSelW, DMOutW, ALUOutW, RFAW, RFRA1, RFRA2, IssueEn, IssueA,
        output ResultW, RFRD1, RFRD2, Busy1, Busy2, SbOvf, SbUnf
    );
endinterface

// File: rtl/wb_regfile_scoreboard.sv
// 32x32 MIPS register file with write-through read bypass and a per-register
// pending-write scoreboard that tells decode when a source is not yet ready.
module wb_regfile_scoreboard #(
    parameter int CNT_W = 2
) (
    input logic                     CLK,
    input logic                     RSTn,
    wb_regfile_scoreboard_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [31:0]      regs [32];
    logic [CNT_W-1:0] cnt  [32];
    logic [31:0]      result;
    logic [31:1]      inc;
    logic [31:1]      dec;
    logic [31:1]      sat;
    logic [31:1]      empty;
    logic             ovf_hit;
    logic             unf_hit;
    logic             sb_ovf;
    logic             sb_unf;
    logic             dec1;
    logic             dec2;

    assign result      = bus.MtoRFSelW ? bus.DMOutW : bus.ALUOutW;
    assign bus.ResultW = result;

    // NOTE: every always_comb output is given a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        inc   = '0;
        dec   = '0;
        sat   = '0;
        empty = '0;
        for (int r = 1; r < 32; r++) begin
            inc[r]   = bus.IssueEn && (bus.IssueA == 5'(r));
            dec[r]   = bus.RFWEW && (bus.RFAW == 5'(r));
            sat[r]   = (cnt[r] == CNT_MAX);
            empty[r] = (cnt[r] == '0);
        end
    end

    // A simultaneous issue and write-back cancel out, so neither flag fires.
    assign ovf_hit = |(inc & ~dec & sat);
    assign unf_hit = |(dec & ~inc & empty);

    assign dec1 = bus.RFWEW && (bus.RFAW == bus.RFRA1);
    assign dec2 = bus.RFWEW && (bus.RFAW == bus.RFRA2);

    assign bus.RFRD1 = (bus.RFRA1 == '0) ? '0 : (dec1 ? result : regs[bus.RFRA1]);
    assign bus.RFRD2 = (bus.RFRA2 == '0) ? '0 : (dec2 ? result : regs[bus.RFRA2]);

    // A write-back landing this cycle retires one pending write before Busy is judged.
    assign bus.Busy1 = (bus.RFRA1 != '0) && (cnt[bus.RFRA1] != CNT_W'(dec1));
    assign bus.Busy2 = (bus.RFRA2 != '0) && (cnt[bus.RFRA2] != CNT_W'(dec2));

    assign bus.SbOvf = sb_ovf;
    assign bus.SbUnf = sb_unf;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            // NOTE: the array is reset explicitly so every register reads 0 after reset; this deliberately maps it to flops, not RAM.
            for (int r = 0; r < 32; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
            sb_ovf <= 1'b0;
            sb_unf <= 1'b0;
        end else begin
            // NOTE: state updates use <= so every register samples pre-edge values regardless of statement order.
            if (bus.RFWEW && (bus.RFAW != '0)) begin
                regs[bus.RFAW] <= result;
            end
            for (int r = 1; r < 32; r++) begin
                if (inc[r] && !dec[r] && !sat[r]) begin
                    cnt[r] <= cnt[r] + CNT_W'(1);
                end else if (dec[r] && !inc[r] && !empty[r]) begin
                    cnt[r] <= cnt[r] - CNT_W'(1);
                end
            end
            if (ovf_hit) begin
                sb_ovf <= 1'b1;
            end
            if (unf_hit) begin
                sb_unf <= 1'b1;
            end
        end
    end
endmodule
